// File: rtl/mul_share_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mul_share_pkg                                          |
// | Description : Shared types and constants for the mul_share_rr slice. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package mul_share_pkg;
   localparam int N_DEF = 8;
   localparam int NREQ  = 2;

   typedef logic [0:0] id_t;

   typedef struct packed {
      logic [N_DEF-1:0] a;
      logic [N_DEF-1:0] b;
      logic             signed_mul;
      id_t              id;
   } mul_req_t;
endpackage
`default_nettype wire

// File: rtl/mul_share_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mul_share_rr_if                                        |
// | Description : Request/response bundle between requesters and the     |
// |               shared multiplier.                                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface mul_share_rr_if
   import mul_share_pkg::*;
#(
   parameter int N = N_DEF
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [2*N-1:0]  req_a;
   logic [2*N-1:0]  req_b;
   logic [NREQ-1:0] req_signed;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [2*N-1:0]  rsp_res;
   id_t             rsp_id;

   modport master (
      output req_valid, req_a, req_b, req_signed, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_signed, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_id
   );
endinterface
`default_nettype wire

// File: rtl/mul_share_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mul_share_rr_arb                                       |
// | Description : Two-way round-robin arbiter owning the priority pointer.|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mul_share_rr_arb
   import mul_share_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output id_t             gnt_id
);
   id_t r_rr_ptr;

   always_comb begin
      gnt_id = r_rr_ptr;
      grant  = '0;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         default: gnt_id = r_rr_ptr;
      endcase
      if (en && (|req)) begin
         grant = (gnt_id == 1'b1) ? 2'b10 : 2'b01;
      end
   end

   // The loser of the last accepted grant gets priority next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= 1'b0;
      end else if (|grant) begin
         r_rr_ptr <= ~gnt_id;
      end
   end
endmodule
`default_nettype wire

// File: rtl/signed_or_unsigned_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : signed_or_unsigned_mul                                 |
// | Description : Combinational N x N multiply, signedness per operation.|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module signed_or_unsigned_mul #(
   parameter int N = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signed_mul,
   output logic [2*N-1:0] prod
);
   logic [2*N-1:0] w_a_ext;
   logic [2*N-1:0] w_b_ext;

   // Extending to 2N bits makes the low 2N bits of a plain multiply exact in both modes.
   assign w_a_ext = {{N{signed_mul & a[N-1]}}, a};
   assign w_b_ext = {{N{signed_mul & b[N-1]}}, b};
   assign prod    = w_a_ext * w_b_ext;
endmodule
`default_nettype wire

// File: rtl/mul_share_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mul_share_rr                                           |
// | Description : One multiplier shared by two requesters, round-robin,  |
// |               two-stage pipeline, tagged response.                   |
// |               Define MUL_SHARE_RR_PERF_EN for grant/stall counters.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mul_share_rr
   import mul_share_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_share_rr_if.slave  bus
`ifdef MUL_SHARE_RR_PERF_EN
   ,
   output logic [31:0]    perf_grant0,
   output logic [31:0]    perf_grant1,
   output logic [31:0]    perf_stall
`endif
);
   logic            w_stall;
   logic            w_s1_can;
   logic [NREQ-1:0] w_grant;
   id_t             w_gnt_id;
   logic [2*N-1:0]  w_prod;

   logic            r_s1_vld;
   logic [N-1:0]    r_s1_a;
   logic [N-1:0]    r_s1_b;
   logic            r_s1_signed;
   id_t             r_s1_id;
   logic            r_s2_vld;
   logic [2*N-1:0]  r_s2_res;
   id_t             r_s2_id;

   assign w_stall  = r_s2_vld & ~bus.rsp_ready;
   assign w_s1_can = ~r_s1_vld | ~w_stall;

   mul_share_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (bus.req_valid),
      .en     (w_s1_can),
      .grant  (w_grant),
      .gnt_id (w_gnt_id)
   );

   assign bus.req_ready = w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld    <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_signed <= 1'b0;
         r_s1_id     <= 1'b0;
      end else if (w_s1_can) begin
         r_s1_vld <= |w_grant;
         if (|w_grant) begin
            r_s1_a      <= w_gnt_id[0] ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
            r_s1_b      <= w_gnt_id[0] ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];
            r_s1_signed <= bus.req_signed[w_gnt_id[0]];
            r_s1_id     <= w_gnt_id;
         end
      end
   end

   signed_or_unsigned_mul #(.N(N)) u_mul (
      .a          (r_s1_a),
      .b          (r_s1_b),
      .signed_mul (r_s1_signed),
      .prod       (w_prod)
   );

   // S2 keeps its contents while the response is back-pressured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld <= 1'b0;
         r_s2_res <= '0;
         r_s2_id  <= 1'b0;
      end else if (!w_stall) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_res <= w_prod;
            r_s2_id  <= r_s1_id;
         end
      end
   end

   assign bus.rsp_valid = r_s2_vld;
   assign bus.rsp_res   = r_s2_res;
   assign bus.rsp_id    = r_s2_id;

`ifdef MUL_SHARE_RR_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
         perf_stall  <= '0;
      end else begin
         perf_grant0 <= perf_grant0 + {31'd0, w_grant[0]};
         perf_grant1 <= perf_grant1 + {31'd0, w_grant[1]};
         perf_stall  <= perf_stall + {31'd0, w_stall};
      end
   end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mul_share_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mul_share_rr                                        |
// | Description : Directed self-checking bench for mul_share_rr (N=8).   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_mul_share_rr;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   logic [16:0] q_rsp[$];

   mul_share_rr_if #(.N(8)) bus ();

`ifdef MUL_SHARE_RR_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_stall;
   logic [31:0] s_g0, s_g1, s_st;
`endif

   mul_share_rr #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MUL_SHARE_RR_PERF_EN
      ,
      .perf_grant0 (perf_grant0),
      .perf_grant1 (perf_grant1),
      .perf_stall  (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A response transfers at the next rising edge when valid & ready are seen here.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) q_rsp.push_back({bus.rsp_id, bus.rsp_res});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s);
      bus.req_a[idx*8 +: 8] = a;
      bus.req_b[idx*8 +: 8] = b;
      bus.req_signed[idx]   = s;
   endtask

   task automatic check_q(input string tag, input int idx, input logic [16:0] exp);
      logic [16:0] v;
      v = (idx < q_rsp.size()) ? q_rsp[idx] : 17'h1ffff;
      check(tag, {15'd0, v}, {15'd0, exp});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_signed = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_res",   {16'd0, bus.rsp_res},   32'd0);
      check("rst_id",    {31'd0, bus.rsp_id},    32'd0);
      check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: signed -1 * 2 from requester 0
      set_req(0, 8'hFF, 8'h02, 1'b1);
      bus.req_valid = 2'b01;
      @(negedge clk);
      check("t1_ready", {30'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 2'b00;
      @(negedge clk);
      check("t1_lat", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
      check("t1_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("t1_res",   {16'd0, bus.rsp_res},   32'hFFFE);
      check("t1_id",    {31'd0, bus.rsp_id},    32'd0);
      tick();

      // 2: unsigned 255 * 2 from requester 1
      set_req(1, 8'hFF, 8'h02, 1'b0);
      bus.req_valid = 2'b10;
      tick();
      bus.req_valid = 2'b00;
      tick();
      @(negedge clk);
      check("t2_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("t2_res",   {16'd0, bus.rsp_res},   32'h01FE);
      check("t2_id",    {31'd0, bus.rsp_id},    32'd1);
      repeat (2) tick();
      q_rsp.delete();

`ifdef MUL_SHARE_RR_PERF_EN
      s_g0 = perf_grant0; s_g1 = perf_grant1; s_st = perf_stall;
`endif
      // 3: both requesters contending, pointer starts at 0
      set_req(0, 8'd3, 8'd5, 1'b0);
      set_req(1, 8'd7, 8'd9, 1'b0);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("t3_grant%0d", i), {30'd0, bus.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();
      end
      bus.req_valid = 2'b00;
      repeat (4) tick();
      check("t3_count", q_rsp.size(), 32'd4);
      check_q("t3_rsp0", 0, {1'b0, 16'h000F});
      check_q("t3_rsp1", 1, {1'b1, 16'h003F});
      check_q("t3_rsp2", 2, {1'b0, 16'h000F});
      check_q("t3_rsp3", 3, {1'b1, 16'h003F});
`ifdef MUL_SHARE_RR_PERF_EN
      check("t7_g0_c3", perf_grant0 - s_g0, 32'd2);
      check("t7_g1_c3", perf_grant1 - s_g1, 32'd2);
      check("t7_st_c3", perf_stall - s_st,  32'd0);
`endif
      q_rsp.delete();

      // 4: sign mode switching back-to-back
      set_req(0, 8'h80, 8'h80, 1'b1);
      bus.req_valid = 2'b01;
      tick();
      set_req(0, 8'h80, 8'h80, 1'b0);
      tick();
      set_req(0, 8'h80, 8'h01, 1'b1);
      tick();
      bus.req_valid = 2'b00;
      repeat (4) tick();
      check("t4_count", q_rsp.size(), 32'd3);
      check_q("t4_rsp0", 0, {1'b0, 16'h4000});
      check_q("t4_rsp1", 1, {1'b0, 16'h4000});
      check_q("t4_rsp2", 2, {1'b0, 16'hFF80});
      q_rsp.delete();

`ifdef MUL_SHARE_RR_PERF_EN
      s_g0 = perf_grant0; s_g1 = perf_grant1; s_st = perf_stall;
`endif
      // 5: five cycles of back-pressure with a queued stream
      bus.rsp_ready = 1'b0;
      set_req(0, 8'd1, 8'd3, 1'b0);
      bus.req_valid = 2'b01;
      @(negedge clk);
      check("t5_acc0", {30'd0, bus.req_ready}, 32'd1);
      tick();
      set_req(0, 8'd2, 8'd3, 1'b0);
      @(negedge clk);
      check("t5_acc1", {30'd0, bus.req_ready}, 32'd1);
      tick();
      set_req(0, 8'd3, 8'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t5_full%0d", i), {30'd0, bus.req_ready}, 32'd0);
         check($sformatf("t5_hold%0d", i), {15'd0, bus.rsp_valid, bus.rsp_res}, {15'd0, 1'b1, 16'h0003});
         tick();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_acc2", {30'd0, bus.req_ready}, 32'd1);
      tick();
      set_req(0, 8'd4, 8'd3, 1'b0);
      @(negedge clk);
      check("t5_acc3", {30'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 2'b00;
      repeat (4) tick();
      check("t5_count", q_rsp.size(), 32'd4);
      check_q("t5_rsp0", 0, {1'b0, 16'h0003});
      check_q("t5_rsp1", 1, {1'b0, 16'h0006});
      check_q("t5_rsp2", 2, {1'b0, 16'h0009});
      check_q("t5_rsp3", 3, {1'b0, 16'h000C});
`ifdef MUL_SHARE_RR_PERF_EN
      check("t7_g0_c5", perf_grant0 - s_g0, 32'd4);
      check("t7_g1_c5", perf_grant1 - s_g1, 32'd0);
      check("t7_st_c5", perf_stall - s_st,  32'd3);
`endif
      q_rsp.delete();

      // 6: reset while both stages hold data
      bus.rsp_ready = 1'b0;
      set_req(0, 8'd5, 8'd5, 1'b0);
      bus.req_valid = 2'b01;
      repeat (2) tick();
      @(negedge clk);
      check("t6_pre", {31'd0, bus.rsp_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      #1;
      check("t6_async", {31'd0, bus.rsp_valid}, 32'd0);
`ifdef MUL_SHARE_RR_PERF_EN
      check("t6_perf", perf_grant0 | perf_grant1 | perf_stall, 32'd0);
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      repeat (4) tick();
      check("t6_stale", q_rsp.size(), 32'd0);
      bus.req_valid = 2'b11;
      @(negedge clk);
      check("t6_ptr", {30'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 2'b00;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
